// File: rtl/uart_controller.sv
// uart_controller: full-duplex 8N1 UART with a fixed-rate transmitter and an oversampling receiver
module uart_controller #(
  parameter int CLOCK_RATE    = 25000000,
  parameter int BAUD_RATE     = 115200,
  parameter int RX_OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       i_Tx_Ready,
  input  logic [7:0] i_Tx_Byte,
  output logic       o_Tx_Active,
  output logic       o_Tx_Data,
  output logic       o_Tx_Done,
  input  logic       i_Rx_Data,
  output logic       o_Rx_Done,
  output logic [7:0] o_Rx_Byte
);
  localparam int CLKS_PER_BIT = CLOCK_RATE / BAUD_RATE;
  localparam int TICK = (CLOCK_RATE + BAUD_RATE * RX_OVERSAMPLE / 2) / (BAUD_RATE * RX_OVERSAMPLE);
  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam int TW = $clog2(TICK + 1);
  localparam int OW = $clog2(RX_OVERSAMPLE);

  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP, TX_CLEANUP} tx_state_e;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT_HIGH} rx_state_e;

  tx_state_e      tx_state_q;
  logic [CW-1:0]  tx_cnt_q;
  logic [2:0]     tx_idx_q;
  logic [7:0]     tx_byte_q;
  logic           tx_data_q, tx_active_q, tx_done_q;
  logic           tx_last;

  rx_state_e      rx_state_q;
  logic           rx_meta_q, rx_sync_q;
  logic [TW-1:0]  rx_tick_q;
  logic [OW-1:0]  rx_os_q;
  logic [2:0]     rx_idx_q;
  logic [7:0]     rx_shift_q, rx_byte_q;
  logic           rx_done_q;
  logic           rx_tick, rx_half, rx_full;

  assign tx_last = tx_cnt_q == CW'(CLKS_PER_BIT - 1);
  assign rx_tick = rx_tick_q == TW'(TICK - 1);
  assign rx_half = rx_os_q == OW'(RX_OVERSAMPLE / 2 - 1);
  assign rx_full = rx_os_q == OW'(RX_OVERSAMPLE - 1);

  // Transmit FSM: the line and status outputs are registered so they change exactly on state transitions
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      tx_state_q  <= TX_IDLE;
      tx_cnt_q    <= '0;
      tx_idx_q    <= '0;
      tx_byte_q   <= '0;
      tx_data_q   <= 1'b1;
      tx_active_q <= 1'b0;
      tx_done_q   <= 1'b0;
    end else begin
      case (tx_state_q)
        TX_IDLE: if (i_Tx_Ready) begin
          tx_byte_q   <= i_Tx_Byte;
          tx_cnt_q    <= '0;
          tx_data_q   <= 1'b0;
          tx_active_q <= 1'b1;
          tx_state_q  <= TX_START;
        end
        TX_START: if (tx_last) begin
          tx_cnt_q   <= '0;
          tx_idx_q   <= '0;
          tx_data_q  <= tx_byte_q[0];
          tx_state_q <= TX_DATA;
        end else tx_cnt_q <= tx_cnt_q + 1'b1;
        TX_DATA: if (tx_last) begin
          tx_cnt_q <= '0;
          if (tx_idx_q == 3'd7) begin
            tx_data_q  <= 1'b1;
            tx_state_q <= TX_STOP;
          end else begin
            tx_idx_q  <= tx_idx_q + 3'd1;
            tx_data_q <= tx_byte_q[tx_idx_q + 3'd1];
          end
        end else tx_cnt_q <= tx_cnt_q + 1'b1;
        TX_STOP: if (tx_last) begin
          tx_cnt_q    <= '0;
          tx_active_q <= 1'b0;
          tx_done_q   <= 1'b1;
          tx_state_q  <= TX_CLEANUP;
        end else tx_cnt_q <= tx_cnt_q + 1'b1;
        TX_CLEANUP: begin
          tx_done_q  <= 1'b0;
          tx_state_q <= TX_IDLE;
        end
        default: tx_state_q <= TX_IDLE;
      endcase
    end
  end

  // Two-flop synchronizer for the asynchronous serial input; resets to the idle-high level
  always_ff @(posedge clk) begin
    if (!reset_n) {rx_sync_q, rx_meta_q} <= 2'b11;
    else {rx_sync_q, rx_meta_q} <= {rx_meta_q, i_Rx_Data};
  end

  // Receive FSM: free-running tick divider realigned at each start bit, oversample counter picks bit centres
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rx_state_q <= RX_IDLE;
      rx_tick_q  <= '0;
      rx_os_q    <= '0;
      rx_idx_q   <= '0;
      rx_shift_q <= '0;
      rx_byte_q  <= '0;
      rx_done_q  <= 1'b0;
    end else begin
      rx_done_q <= 1'b0;
      rx_tick_q <= rx_tick ? '0 : rx_tick_q + 1'b1;
      case (rx_state_q)
        RX_IDLE: if (!rx_sync_q) begin
          rx_tick_q  <= '0;
          rx_os_q    <= '0;
          rx_state_q <= RX_START;
        end
        RX_START: if (rx_tick) begin
          rx_os_q <= rx_half ? '0 : rx_os_q + 1'b1;
          if (rx_half) begin
            rx_idx_q   <= '0;
            rx_state_q <= rx_sync_q ? RX_IDLE : RX_DATA;
          end
        end
        RX_DATA: if (rx_tick) begin
          rx_os_q <= rx_full ? '0 : rx_os_q + 1'b1;
          if (rx_full) begin
            rx_shift_q <= {rx_sync_q, rx_shift_q[7:1]};
            rx_idx_q   <= rx_idx_q + 3'd1;
            if (rx_idx_q == 3'd7) rx_state_q <= RX_STOP;
          end
        end
        RX_STOP: if (rx_tick) begin
          rx_os_q <= rx_full ? '0 : rx_os_q + 1'b1;
          if (rx_full) begin
            if (rx_sync_q) begin
              rx_byte_q  <= rx_shift_q;
              rx_done_q  <= 1'b1;
              rx_state_q <= RX_IDLE;
            end else rx_state_q <= RX_WAIT_HIGH;
          end
        end
        RX_WAIT_HIGH: if (rx_sync_q) rx_state_q <= RX_IDLE;
        default: rx_state_q <= RX_IDLE;
      endcase
    end
  end

  assign o_Tx_Active = tx_active_q;
  assign o_Tx_Data   = tx_data_q;
  assign o_Tx_Done   = tx_done_q;
  assign o_Rx_Done   = rx_done_q;
  assign o_Rx_Byte   = rx_byte_q;
endmodule

// File: tb/tb_uart_controller.sv
// tb_uart_controller: directed and randomized checks of uart_controller against a bit-level frame model
module tb_uart_controller;
  localparam int CPB = 25000000 / 115200;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       i_Tx_Ready = 1'b0;
  logic [7:0] i_Tx_Byte = 8'h00;
  logic       o_Tx_Active, o_Tx_Data, o_Tx_Done, o_Rx_Done;
  logic [7:0] o_Rx_Byte;
  logic       i_Rx_Data;
  logic       loop_en = 1'b0;
  logic       rx_drv = 1'b1;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int long_rx = 0;
  int long_tx = 0;
  logic prev_rx_done = 1'b0, prev_tx_done = 1'b0, prev_active = 1'b0;
  logic [7:0] rx_q[$];
  int done_q[$];
  int start_q[$];
  logic [7:0] lb[10] = '{8'h01, 8'h10, 8'h22, 8'h32, 8'h55, 8'hAA, 8'hAB, 8'h88, 8'h00, 8'h00};

  assign i_Rx_Data = loop_en ? o_Tx_Data : rx_drv;

  uart_controller dut (
    .clk(clk), .reset_n(reset_n),
    .i_Tx_Ready(i_Tx_Ready), .i_Tx_Byte(i_Tx_Byte),
    .o_Tx_Active(o_Tx_Active), .o_Tx_Data(o_Tx_Data), .o_Tx_Done(o_Tx_Done),
    .i_Rx_Data(i_Rx_Data), .o_Rx_Done(o_Rx_Done), .o_Rx_Byte(o_Rx_Byte)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Event recorder: received bytes, TX done / frame-start cycles, and over-long strobes
  always @(negedge clk) begin
    if (o_Rx_Done === 1'b1) rx_q.push_back(o_Rx_Byte);
    if (o_Rx_Done === 1'b1 && prev_rx_done === 1'b1) long_rx++;
    if (o_Tx_Done === 1'b1) done_q.push_back(cyc);
    if (o_Tx_Done === 1'b1 && prev_tx_done === 1'b1) long_tx++;
    if (o_Tx_Active === 1'b1 && prev_active !== 1'b1) start_q.push_back(cyc);
    prev_rx_done = o_Rx_Done;
    prev_tx_done = o_Tx_Done;
    prev_active = o_Tx_Active;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected line level t cycles after the start bit begins: start 0, data LSB first, stop 1
  function automatic logic tx_model(input logic [7:0] b, input int t);
    int k;
    k = t / CPB;
    return k == 0 ? 1'b0 : (k <= 8 ? b[k-1] : 1'b1);
  endfunction

  task automatic tx_wave(input logic [7:0] b);
    int errs, act;
    errs = 0;
    act = 0;
    i_Tx_Byte = b;
    i_Tx_Ready = 1'b1;
    @(negedge clk);
    i_Tx_Ready = 1'b0;
    i_Tx_Byte = ~b;
    for (int t = 0; t < 10 * CPB; t++) begin
      if (o_Tx_Data !== tx_model(b, t) || o_Tx_Done !== 1'b0) errs++;
      if (o_Tx_Active === 1'b1) act++;
      @(negedge clk);
    end
    chk("tx_wave_line", errs, 0);
    chk("tx_active_len", act, 10 * CPB);
    chk("tx_done_pulse", o_Tx_Done, 1);
    chk("tx_active_at_done", o_Tx_Active, 0);
    chk("tx_line_at_done", o_Tx_Data, 1);
    @(negedge clk);
    chk("tx_done_after", o_Tx_Done, 0);
    chk("tx_active_after", o_Tx_Active, 0);
    chk("tx_line_after", o_Tx_Data, 1);
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop);
    rx_drv = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_drv = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx_drv = stop;
    repeat (CPB) @(negedge clk);
    rx_drv = 1'b1;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic rx_good(input string tag, input logic [7:0] b);
    int n;
    n = rx_q.size();
    send_rx(b, 1'b1);
    chk({tag, "_count"}, rx_q.size(), n + 1);
    chk({tag, "_byte"}, rx_q.size() > n ? rx_q[n] : 8'hxx, b);
    chk({tag, "_out"}, o_Rx_Byte, b);
  endtask

  initial begin
    int n, ns, nd, w;
    logic [7:0] b;
    lb[8] = 8'($urandom);
    lb[9] = 8'($urandom);
    repeat (3) @(negedge clk);
    chk("rst_tx_line", o_Tx_Data, 1);
    chk("rst_tx_active", o_Tx_Active, 0);
    chk("rst_tx_done", o_Tx_Done, 0);
    chk("rst_rx_done", o_Rx_Done, 0);
    chk("rst_rx_byte", o_Rx_Byte, 0);
    reset_n = 1'b1;
    repeat (5) @(negedge clk);

    tx_wave(8'h55);
    tx_wave(8'($urandom));
    repeat (10) @(negedge clk);

    n = rx_q.size();
    loop_en = 1'b1;
    i_Tx_Byte = lb[0];
    i_Tx_Ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      w = 0;
      @(negedge clk);
      while (o_Rx_Done !== 1'b1 && w < 3000) begin
        @(negedge clk);
        w++;
      end
      chk("lb_wait", w < 3000, 1);
      if (i < 9) i_Tx_Byte = lb[i+1];
      else i_Tx_Ready = 1'b0;
    end
    repeat (3000) @(negedge clk);
    chk("lb_count", rx_q.size(), n + 10);
    for (int i = 0; i < 10; i++) chk("lb_byte", rx_q.size() > n + i ? rx_q[n+i] : 8'hxx, lb[i]);

    loop_en = 1'b0;
    rx_drv = 1'b1;
    repeat (20) @(negedge clk);
    rx_good("rx_a5", 8'hA5);
    n = rx_q.size();
    send_rx(8'hA5, 1'b0);
    repeat (CPB) @(negedge clk);
    chk("rx_frame_err_count", rx_q.size(), n);
    chk("rx_frame_err_hold", o_Rx_Byte, 8'hA5);
    rx_good("rx_3c", 8'h3C);
    rx_good("rx_rand", 8'($urandom));

    n = rx_q.size();
    rx_drv = 1'b0;
    repeat (3) @(negedge clk);
    rx_drv = 1'b1;
    repeat (400) @(negedge clk);
    chk("glitch_count", rx_q.size(), n);
    rx_good("glitch_next", 8'($urandom) | 8'h01);

    loop_en = 1'b1;
    b = 8'($urandom);
    i_Tx_Byte = b;
    i_Tx_Ready = 1'b1;
    @(negedge clk);
    i_Tx_Ready = 1'b0;
    repeat (4 * CPB + 100) @(negedge clk);
    n = rx_q.size();
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    chk("mid_rst_line", o_Tx_Data, 1);
    chk("mid_rst_active", o_Tx_Active, 0);
    chk("mid_rst_tx_done", o_Tx_Done, 0);
    chk("mid_rst_rx_done", o_Rx_Done, 0);
    chk("mid_rst_rx_byte", o_Rx_Byte, 0);
    repeat (50) @(negedge clk);
    nd = done_q.size();
    i_Tx_Byte = 8'h81;
    i_Tx_Ready = 1'b1;
    @(negedge clk);
    i_Tx_Ready = 1'b0;
    repeat (10 * CPB + 300) @(negedge clk);
    chk("post_rst_tx_done", done_q.size(), nd + 1);
    chk("post_rst_count", rx_q.size(), n + 1);
    chk("post_rst_byte", rx_q.size() > n ? rx_q[n] : 8'hxx, 8'h81);

    n = rx_q.size();
    ns = start_q.size();
    nd = done_q.size();
    i_Tx_Byte = 8'hFF;
    i_Tx_Ready = 1'b1;
    w = 0;
    while (rx_q.size() < n + 5 && w < 6 * 10 * CPB) begin
      @(negedge clk);
      w++;
    end
    i_Tx_Ready = 1'b0;
    chk("b2b_wait", w < 6 * 10 * CPB, 1);
    repeat (3000) @(negedge clk);
    chk("b2b_rx_count", rx_q.size(), n + 5);
    chk("b2b_frames", start_q.size(), ns + 5);
    for (int i = 0; i < 5; i++) chk("b2b_byte", rx_q.size() > n + i ? rx_q[n+i] : 8'hxx, 8'hFF);
    for (int i = 1; i < 5; i++)
      chk("b2b_gap", (start_q.size() > ns + i && done_q.size() > nd + i - 1) ?
          start_q[ns+i] - done_q[nd+i-1] : -1, 2);

    chk("rx_done_width", long_rx, 0);
    chk("tx_done_width", long_tx, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/uart_controller.md
Name: uart_controller

Overview:
- Full-duplex 8N1 UART: 8 data bits, no parity, 1 stop bit, LSB first.
- Transmitter serializes a byte on request; receiver oversamples the serial input and delivers received bytes with a one-cycle strobe.
- Both halves share one clock and are otherwise independent, so o_Tx_Data may be looped back to i_Rx_Data.
- Sits between on-chip byte producers/consumers and the external serial pins.

Parameters:
- CLOCK_RATE, 25000000, system clock frequency in Hz.
- BAUD_RATE, 115200, serial bit rate in bits/s.
- RX_OVERSAMPLE, 16, receiver samples per bit period (even, ≥4).

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- reset_n  input  1  reset; synchronous, active-low.
- i_Tx_Ready  input  1  transmit request (level); sampled while the transmitter is idle.
- i_Tx_Byte  input  8  byte to transmit; latched at frame start.
- o_Tx_Active  output  1  high while a frame (start, data, stop) is being driven.
- o_Tx_Data  output  1  serial TX line; idles high.
- o_Tx_Done  output  1  one-cycle pulse at the end of the stop bit.
- i_Rx_Data  input  1  serial RX line; asynchronous.
- o_Rx_Done  output  1  one-cycle pulse when a valid byte is received.
- o_Rx_Byte  output  8  last valid received byte; holds until the next valid byte.

Behaviour:
- Reset (reset_n low at a clk edge):
  - o_Tx_Data=1; o_Tx_Active=0; o_Tx_Done=0; o_Rx_Done=0; o_Rx_Byte=0.
  - Both FSMs return to IDLE and all counters clear.
  - Reset mid-frame aborts the frame immediately; TX line returns high.
- TX bit time: CLKS_PER_BIT = CLOCK_RATE/BAUD_RATE, integer division (217 at defaults).
- TX FSM: IDLE -> START -> DATA -> STOP -> CLEANUP -> IDLE.
  - IDLE: line high, Active=0. If i_Tx_Ready=1 at an edge: latch i_Tx_Byte, go to START. From that edge, o_Tx_Data=0 and Active=1.
  - START: hold 0 for CLKS_PER_BIT cycles.
  - DATA: bits 0..7 of the latched byte, each held CLKS_PER_BIT cycles.
  - STOP: line 1 for CLKS_PER_BIT cycles.
  - CLEANUP: one cycle with Done=1, Active=0, line 1. Then IDLE.
  - With i_Tx_Ready held high, the next start bit begins 2 cycles after Done rises. i_Tx_Byte is re-sampled at that frame start.
  - Changes to i_Tx_Byte or i_Tx_Ready during a frame have no effect on that frame.
  - Frame length: exactly 10*CLKS_PER_BIT cycles of Active=1.
- RX timing:
  - i_Rx_Data passes through a 2-FF synchronizer; all RX decisions use the synchronized value.
  - Sample tick period: TICK = (CLOCK_RATE + BAUD_RATE*RX_OVERSAMPLE/2) / (BAUD_RATE*RX_OVERSAMPLE), rounded (14 at defaults).
  - The tick counter restarts on entering START.
- RX FSM: IDLE -> START -> DATA -> STOP -> (IDLE | WAIT_HIGH).
  - IDLE: synchronized line low (level, not edge) -> START.
  - START: after RX_OVERSAMPLE/2 ticks, re-check the line. Low: go to DATA. High: glitch, return to IDLE with no output.
  - DATA: every RX_OVERSAMPLE ticks, shift in one bit, LSB first, 8 bits.
  - STOP: after RX_OVERSAMPLE ticks, sample the line.
    - Sample 1: o_Rx_Byte updates and o_Rx_Done pulses for exactly one cycle, both in the same cycle. Then IDLE.
    - Sample 0 (framing error): no Done, o_Rx_Byte unchanged. Go to WAIT_HIGH and stay until the line is high, then IDLE.
- RX resynchronizes on every start bit, so it tolerates the rounding mismatch between TICK*RX_OVERSAMPLE and CLKS_PER_BIT. It also accepts frames separated by a single stop bit.
- RX Done occurs mid-stop-bit, before TX CLEANUP. A new i_Tx_Byte applied on Rx_Done in loopback is therefore used by the next TX frame.

Test Plan:
- Loopback, defaults:
  - Stimulus: i_Rx_Data tied to o_Tx_Data; i_Tx_Ready held 1. After each o_Rx_Done rise, apply the next byte of 01,10,22,32,55,AA,AB,88.
  - Required: eight Done pulses; o_Rx_Byte equals each sent byte in order; no extra pulses.
- TX waveform:
  - Stimulus: i_Tx_Byte=0x55, single request.
  - Required: line sequence 0,1,0,1,0,1,0,1,0,1, each exactly 217 cycles.
  - Required: Active high 2170 cycles; one-cycle Done at the end; Active=0 with line high the cycle after.
- RX direct drive:
  - Stimulus: frame for 0xA5 at a bit period of 217 cycles, stop bit high.
  - Required: one Done pulse; o_Rx_Byte=0xA5.
  - Stimulus: the same frame with stop bit low.
  - Required: no Done, o_Rx_Byte unchanged; a subsequent valid 0x3C is received correctly.
- Glitch rejection:
  - Stimulus: low pulse of 3 cycles on an idle i_Rx_Data.
  - Required: no Done; RX back in IDLE; the next valid frame is received.
- Reset mid-operation:
  - Stimulus: reset_n=0 for one edge during TX data bit 3 and RX data bit 3.
  - Required: after that edge, o_Tx_Data=1, Active=0, Done=0, o_Rx_Byte=0. A following frame of 0x81 is transmitted and received correctly.
- Back-to-back:
  - Stimulus: i_Tx_Ready held high with a constant byte 0xFF.
  - Required: each start bit begins 2 cycles after the prior o_Tx_Done rise; loopback RX reports 0xFF for every frame.
